// File: rtl/s2_kes_dcme_array.sv
// Degree-computationless modified-Euclidean key-equation solver: N-cell systolic array over
// GF(2^M) running ITER iterations per codeword, with load/stall/valid-ready control.
module s2_kes_dcme_array #(
  parameter int unsigned M         = 8,
  parameter logic [M:0]  PRIM_POLY = 9'h11D,
  parameter int unsigned N         = 17,
  parameter int unsigned ITER      = 16,
  parameter int unsigned DW        = $clog2(ITER) + 2,
  parameter int unsigned CW        = $clog2(ITER + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            in_ready,
  input  logic [N*M-1:0]  r_init,
  input  logic [N*M-1:0]  q_init,
  input  logic            stall,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*M-1:0]  r_final,
  output logic [N*M-1:0]  q_final,
  output logic [DW-1:0]   deg_diff,
  output logic [CW-1:0]   swap_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [DW-1:0] DOne = DW'(1);
  localparam logic [CW-1:0] COne = CW'(1);
  localparam logic [CW-1:0] ILast = CW'(ITER - 1);

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = x;
    for (int k = 0; k < int'(M); k++) begin
      if (y[k]) acc = acc ^ sh;
      sh = sh[M-1] ? ((sh << 1) ^ PRIM_POLY[M-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  state_e        state_q, state_d;
  logic [M-1:0]  r_q [N];
  logic [M-1:0]  r_d [N];
  logic [M-1:0]  q_q [N];
  logic [M-1:0]  q_d [N];
  logic [M-1:0]  r_up [N+1];
  logic [M-1:0]  q_up [N+1];
  logic [M-1:0]  upd [N];
  logic [DW-1:0] d_q, d_d;
  logic [CW-1:0] sc_q, sc_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [M-1:0]  lead_a, lead_b;

  assign lead_a = r_q[0];
  assign lead_b = q_q[0];

  // Neighbour view with an implicit zero cell past the end of the array.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      r_up[i] = r_q[i];
      q_up[i] = q_q[i];
    end
    r_up[N] = '0;
    q_up[N] = '0;
    for (int i = 0; i < int'(N); i++) begin
      upd[i] = gf_mul(lead_b, r_up[i+1]) ^ gf_mul(lead_a, q_up[i+1]);
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    sc_d    = sc_q;
    iter_d  = iter_q;
    for (int i = 0; i < int'(N); i++) begin
      r_d[i] = r_q[i];
      q_d[i] = q_q[i];
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int i = 0; i < int'(N); i++) begin
            r_d[i] = r_init[i*M +: M];
            q_d[i] = q_init[i*M +: M];
          end
          d_d     = '0;
          sc_d    = '0;
          iter_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!stall) begin
          iter_d = iter_q + COne;
          if (iter_q == ILast) state_d = StDone;
          if (lead_b == '0) begin
            for (int i = 0; i < int'(N); i++) q_d[i] = q_up[i+1];
            d_d = d_q - DOne;
          end else if ((lead_a != '0) && d_q[DW-1]) begin
            for (int i = 0; i < int'(N); i++) begin
              r_d[i] = upd[i];
              q_d[i] = r_q[i];
            end
            d_d  = ~d_q;  // -d-1 in two's complement
            sc_d = sc_q + COne;
          end else begin
            for (int i = 0; i < int'(N); i++) r_d[i] = upd[i];
            d_d = d_q - DOne;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      d_q     <= '0;
      sc_q    <= '0;
      iter_q  <= '0;
      for (int i = 0; i < int'(N); i++) begin
        r_q[i] <= '0;
        q_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      sc_q    <= sc_d;
      iter_q  <= iter_d;
      for (int i = 0; i < int'(N); i++) begin
        r_q[i] <= r_d[i];
        q_q[i] <= q_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      r_final[i*M +: M] = r_q[i];
      q_final[i*M +: M] = q_q[i];
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign deg_diff  = d_q;
  assign swap_cnt  = sc_q;

endmodule

// File: tb/tb_s2_kes_dcme_array.sv
// Scoreboarded bench for s2_kes_dcme_array: default-size array against a recurrence model, plus
// two small directed configurations with hand-derived results.
module tb_s2_kes_dcme_array;

  localparam int N  = 17;
  localparam int NW = N * 8;

  logic clk = 1'b0;
  logic rst, start, stall, out_ready;
  logic [NW-1:0] r_init, q_init, r_final, q_final;
  logic in_ready, busy, out_valid;
  logic [5:0] deg_diff;
  logic [4:0] swap_cnt;

  logic start_s, in_ready_s, busy_s, out_valid_s;
  logic [31:0] r_init_s, q_init_s, r_final_s, q_final_s;
  logic [2:0] deg_s;
  logic [1:0] sc_s;

  logic start_g, in_ready_g, busy_g, out_valid_g;
  logic [15:0] r_init_g, q_init_g, r_final_g, q_final_g;
  logic [1:0] deg_g;
  logic       sc_g;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NW-1:0] r;
    logic [NW-1:0] q;
    logic [5:0]    d;
    logic [4:0]    sc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  s2_kes_dcme_array dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .r_init(r_init),
    .q_init(q_init), .stall(stall), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .r_final(r_final), .q_final(q_final), .deg_diff(deg_diff), .swap_cnt(swap_cnt)
  );

  s2_kes_dcme_array #(.N(4), .ITER(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .in_ready(in_ready_s), .r_init(r_init_s),
    .q_init(q_init_s), .stall(stall), .busy(busy_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .r_final(r_final_s), .q_final(q_final_s), .deg_diff(deg_s),
    .swap_cnt(sc_s)
  );

  s2_kes_dcme_array #(.N(2), .ITER(1)) dut_g (
    .clk(clk), .rst(rst), .start(start_g), .in_ready(in_ready_g), .r_init(r_init_g),
    .q_init(q_init_g), .stall(stall), .busy(busy_g), .out_valid(out_valid_g),
    .out_ready(out_ready), .r_final(r_final_g), .q_final(q_final_g), .deg_diff(deg_g),
    .swap_cnt(sc_g)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Full polynomial product followed by reduction from the top bit down.
  function automatic logic [7:0] mdl_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    logic [15:0] poly;
    p    = '0;
    poly = 16'h011D;
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (16'(x) << i);
    for (int j = 15; j >= 8; j--) if (p[j]) p = p ^ (poly << (j - 8));
    return p[7:0];
  endfunction

  task automatic push_model(input logic [NW-1:0] ri, input logic [NW-1:0] qi);
    logic [7:0] r [N+1];
    logic [7:0] q [N+1];
    logic [7:0] nr [N];
    logic [7:0] a, b;
    int d, sc;
    exp_t e;
    d  = 0;
    sc = 0;
    for (int i = 0; i < N; i++) begin
      r[i] = ri[i*8 +: 8];
      q[i] = qi[i*8 +: 8];
    end
    r[N] = 8'h00;
    q[N] = 8'h00;
    for (int it = 0; it < 16; it++) begin
      a = r[0];
      b = q[0];
      if (b == 8'h00) begin
        for (int i = 0; i < N; i++) q[i] = q[i+1];
        d = d - 1;
      end else begin
        for (int i = 0; i < N; i++) nr[i] = mdl_mul(b, r[i+1]) ^ mdl_mul(a, q[i+1]);
        if (a != 8'h00 && d < 0) begin
          for (int i = 0; i < N; i++) q[i] = r[i];
          d  = -d - 1;
          sc = sc + 1;
        end else begin
          d = d - 1;
        end
        for (int i = 0; i < N; i++) r[i] = nr[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      e.r[i*8 +: 8] = r[i];
      e.q[i*8 +: 8] = q[i];
    end
    e.d  = d[5:0];
    e.sc = sc[4:0];
    sb.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_r"}, r_final, e.r);
      chk({tag, "_q"}, q_final, e.q);
      chk({tag, "_d"}, deg_diff, e.d);
      chk({tag, "_sc"}, swap_cnt, e.sc);
    end
  endtask

  function automatic logic [NW-1:0] rnd_vec(input int zero_pct);
    logic [NW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*8 +: 8] = ($urandom_range(0, 99) < zero_pct) ? 8'h00 : 8'($urandom);
    return v;
  endfunction

  task automatic launch(input logic [NW-1:0] ri, input logic [NW-1:0] qi);
    r_init = ri;
    q_init = qi;
    start  = 1'b1;
    step();
    start  = 1'b0;
    push_model(ri, qi);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_r"}, r_final, '0);
    chk({tag, "_q"}, q_final, '0);
    chk({tag, "_d"}, deg_diff, '0);
    chk({tag, "_sc"}, swap_cnt, '0);
  endtask

  initial begin
    int cyc;
    bit done;
    logic [NW-1:0] rv;
    exp_t e;

    rst = 1'b1; start = 1'b0; stall = 1'b0; out_ready = 1'b0;
    start_s = 1'b0; start_g = 1'b0;
    r_init = '0; q_init = '0; r_init_s = '0; q_init_s = '0; r_init_g = '0; q_init_g = '0;
    step(); step();
    rst = 1'b0;
    check_reset("rst0");

    // Reset in the middle of a run discards the codeword.
    launch(rnd_vec(10), rnd_vec(10));
    chk("run_busy", busy, 1'b1);
    repeat (5) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    sb.delete();
    check_reset("rst_mid");

    // All-SHIFT: Q empty, R untouched.
    rv = rnd_vec(0);
    launch(rv, '0);
    chk("shift_busy", busy, 1'b1);
    repeat (15) step();
    chk("shift_ov15", out_valid, 1'b0);
    step();
    chk("shift_ov16", out_valid, 1'b1);
    chk("shift_r", r_final, rv);
    chk("shift_q", q_final, '0);
    chk("shift_d", deg_diff, 6'b110000);
    chk("shift_sc", swap_cnt, 5'd0);
    check_pop("shift");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("shift_in_ready", in_ready, 1'b1);

    // UPDATE then SWAP on the 4-cell, 2-iteration array.
    r_init_s = 32'h0000_0301;
    q_init_s = 32'h0000_0201;
    start_s  = 1'b1;
    step();
    start_s  = 1'b0;
    step();
    chk("us_it1_r", r_final_s, 32'h0000_0001);
    chk("us_it1_q", q_final_s, 32'h0000_0201);
    chk("us_it1_d", deg_s, 3'b111);
    chk("us_it1_ov", out_valid_s, 1'b0);
    step();
    chk("us_ov", out_valid_s, 1'b1);
    chk("us_r", r_final_s, 32'h0000_0002);
    chk("us_q", q_final_s, 32'h0000_0001);
    chk("us_d", deg_s, 3'b000);
    chk("us_sc", sc_s, 2'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("us_in_ready", in_ready_s, 1'b1);

    // Field reduction: 0x80 * 0x02 wraps to 0x1D.
    r_init_g = 16'h0202;
    q_init_g = 16'h0080;
    start_g  = 1'b1;
    step();
    start_g  = 1'b0;
    step();
    chk("gf_ov", out_valid_g, 1'b1);
    chk("gf_r", r_final_g, 16'h001D);
    chk("gf_q", q_final_g, 16'h0080);
    chk("gf_d", deg_g, 2'b11);
    chk("gf_sc", sc_g, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("gf_in_ready", in_ready_g, 1'b1);

    // Stall and backpressure with ignored start pulses.
    launch(rnd_vec(20), rnd_vec(20));
    repeat (3) step();
    stall = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_busy", busy, 1'b1);
    end
    stall = 1'b0;
    start = 1'b0;
    cyc = 8;
    while (!out_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk("stall_latency", cyc, 21);
    e = sb[0];
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_ov", out_valid, 1'b1);
      chk("bp_busy", busy, 1'b0);
      chk("bp_r", r_final, e.r);
      chk("bp_q", q_final, e.q);
    end
    start = 1'b0;
    check_pop("bp");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_in_ready", in_ready, 1'b1);
    chk("bp_ov_drop", out_valid, 1'b0);

    // Randomised codewords with random stall, out_ready and start noise.
    for (int n = 0; n < 1000; n++) begin
      chk("rnd_idle", in_ready, 1'b1);
      launch(rnd_vec(30), rnd_vec(30));
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 200) begin
        stall = ($urandom_range(0, 3) == 0);
        start = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check_pop("rnd");
          step();
          start = 1'b0; stall = 1'b0; out_ready = 1'b0;
          chk("rnd_in_ready", in_ready, 1'b1);
          done = 1'b1;
        end else begin
          step();
          cyc++;
        end
      end
      if (!done) begin
        total++;
        bad++;
        $error("FAIL rnd_timeout observed=%0d cycles expected=out_valid", cyc);
        start = 1'b0; stall = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s2_kes_dcme_array.md
# s2_kes_dcme_array

Parametrised key-equation-solver engine for the RS decoder back end. It holds a systolic array of N coefficient cells over GF(2^M), each with an R and a Q register, and runs ITER iterations of the degree-computationless modified-Euclidean recurrence under its own FSM. Upstream composes and presents the initial R/Q polynomials. The array sends the final polynomials downstream (Chien/Forney) through a valid/ready handshake and supports a stall input.

## Interface
- M, 8, symbol width (GF(2^M))
- PRIM_POLY, 9'h11D, primitive polynomial, M+1 bits, MSB = x^M
- N, 17, number of cells; cell 0 holds the leading coefficient
- ITER, 16, iterations per codeword (>=1)
- DW, $clog2(ITER)+2, width of signed degree-difference register
- CW, $clog2(ITER+1), width of swap counter
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  load request; accepted only when in_ready=1
- in_ready  out  1  high in IDLE
- r_init  in  N*M  initial R; cell i at bits [i*M +: M]
- q_init  in  N*M  initial Q, same packing
- stall  in  1  freezes RUN for that cycle
- busy  out  1  high in RUN
- out_valid  out  1  high in DONE
- out_ready  in  1  downstream accept
- r_final  out  N*M  R registers (direct)
- q_final  out  N*M  Q registers (direct)
- deg_diff  out  DW  signed d register
- swap_cnt  out  CW  number of SWAP iterations this codeword

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: when start=1, load R←r_init, Q←q_init, d←0, swap_cnt←0, iter←0, and go to RUN. When start=0, hold.
- RUN, stall=1: all registers hold.
- RUN, stall=0: perform one iteration. Define a=R[0] and b=Q[0]. For cell N-1, R[N]=Q[N]=0. upd_i = b·R[i+1] ⊕ a·Q[i+1] (GF multiply mod PRIM_POLY, ⊕ = XOR).
  - SHIFT when b==0: Q[i]←Q[i+1], Q[N-1]←0; R holds; d←d−1.
  - SWAP when b≠0, a≠0 and d<0: R[i]←upd_i; Q[i]←R[i] (unshifted); d←−d−1; swap_cnt+1.
  - UPDATE otherwise: R[i]←upd_i; Q holds; d←d−1.
  - After each iteration, iter+1. On the iteration with iter==ITER−1, go to DONE.
- DONE: outputs stable. When out_ready=1, go to IDLE. start is ignored in RUN and in DONE.
- Arithmetic: d is two's complement, DW bits; it never overflows, because |d|≤ITER. swap_cnt is unsigned and cannot exceed ITER.
- The GF multiplier is a combinational function of M and PRIM_POLY (shift-and-reduce). There are 2N instances.

## Timing
- Reset values: state IDLE; all R and Q = 0; d=0; swap_cnt=0; iter=0; in_ready=1; busy=0; out_valid=0. r_final, q_final, deg_diff and swap_cnt outputs read 0.
- rst asserted in any state, including mid-RUN or in DONE with out_valid high, returns the block to the reset values at the next edge. The result in flight is discarded.
- Start sampled at edge k: the load occurs at edge k, busy=1 from k.
- With no stall, iterations occur at edges k+1 through k+ITER. out_valid=1 from edge k+ITER, so latency is ITER cycles from the accepting edge.
- Each stalled RUN cycle adds one cycle of latency.
- Handshake: a transfer happens on any edge where out_valid & out_ready. in_ready rises at that same edge. A new start is accepted at the next edge at the earliest.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- in_ready, busy and out_valid are decoded from registered state (no combinational path from inputs).

## Test plan
- Reset/idle: hold rst 3 cycles mid-RUN → next cycle in_ready=1, out_valid=0, r_final=q_final=0, deg_diff=0, swap_cnt=0.
- All-SHIFT: defaults; q_init=0, r_init random; start → out_valid after exactly 16 cycles; r_final==r_init, q_final=0, deg_diff=−16, swap_cnt=0.
- UPDATE then SWAP: N=4, ITER=2; R=[01,03,00,00], Q=[01,02,00,00] → iteration 1 UPDATE: R=[01,00,00,00], d=−1. Iteration 2 SWAP: R=[02,00,00,00], Q=[01,00,00,00], d=0, swap_cnt=1.
- GF reduction: N=2, ITER=1; R=[02,02], Q=[80,00] → R=[1D,00], Q unchanged, d=−1.
- Stall/backpressure: defaults; stall high for 5 cycles mid-RUN, and out_ready low for 10 cycles in DONE → out_valid after 21 cycles. Outputs are stable while waiting. start pulses during RUN/DONE are ignored. in_ready rises on the accepting edge.
- Randomised: 1000 codewords with random init, random stall and random out_ready → r_final, q_final, deg_diff and swap_cnt match the bit-exact recurrence model.
